gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq: RTL and testbench

- Parametrised power-switch sequencer for a gated power domain, built from NSEG header-switch segments.
- Successor to the port-less physical-only cells: it actively drives the switch segments instead of just occupying a row.
- Powers up segments one at a time, waits for each segment's acknowledge plus a programmable settle delay, then releases isolation.
- Power-down runs in reverse order. Sits between the always-on power controller and the switch/isolation cells of one domain.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv | 191 +++++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
`default_nettype none
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq
// Brief   : Power-switch sequencer for one gated domain. It ramps NSEG header
//           segments up and down one at a time with acks and a settle delay.
//           Optional ack timeout is enabled by GF180MCU_FD_SC_MCU9T5V0_PWRSW_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(
    parameter int NSEG    = 4,
    parameter int DLY_W   = 4,
    parameter int TMO_CYC = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PWR_REQ,
    input  logic [DLY_W-1:0] DLY,
    input  logic [NSEG-1:0]  SW_ACK,
    output logic [NSEG-1:0]  SW_EN,
    output logic             ISO_EN,
    output logic             PWR_GOOD,
    output logic             BUSY,
    output logic             FAULT
);

    localparam int c_NW = $clog2(NSEG + 1);
    localparam int c_AW = 1 << c_NW;

    typedef enum logic [2:0] {
        S_OFF = 3'd0,
        S_UP  = 3'd1,
        S_ON  = 3'd2,
        S_ISO = 3'd3,
        S_DN  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [c_NW-1:0]   non_q, non_d;
    logic [DLY_W-1:0]  cnt_q, cnt_d;
    logic [NSEG-1:0]   sw_en_q, sw_en_d;
    logic              iso_q, iso_d;
    logic              pg_q, pg_d;
    logic              busy_q, busy_d;
    logic [c_AW-1:0]   ack_ext;
    logic              cnt_zero;
    logic              up_ack;
    logic              dn_ack;
    logic              blocked;

    // Padding the ack vector to a power of two keeps every index in range.
    assign ack_ext  = c_AW'(SW_ACK);
    assign up_ack   = ack_ext[non_q - c_NW'(1)];
    assign dn_ack   = ack_ext[non_q];
    assign cnt_zero = (cnt_q == '0);

`ifdef GF180MCU_FD_SC_MCU9T5V0_PWRSW_TIMEOUT_EN
    localparam int c_WW = $clog2(TMO_CYC + 1);

    logic [c_WW-1:0] wait_q, wait_d;
    logic            fault_q, fault_d;
    logic            stall;

    assign stall   = cnt_zero &&
                     ((state_q == S_UP && PWR_REQ && !up_ack) ||
                      (state_q == S_DN && !PWR_REQ && dn_ack));
    assign blocked = fault_q;
    assign FAULT   = fault_q;
`else
    assign blocked = 1'b0;
    assign FAULT   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        non_d   = non_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - DLY_W'(1);

        case (state_q)
            S_OFF: begin
                if (PWR_REQ && !blocked) begin
                    state_d = S_UP;
                    non_d   = c_NW'(1);
                    cnt_d   = DLY;
                end
            end
            S_UP: begin
                if (!PWR_REQ) begin
                    state_d = S_DN;
                    non_d   = non_q - c_NW'(1);
                    cnt_d   = DLY;
                end else if (cnt_zero && up_ack) begin
                    if (non_q == c_NW'(NSEG)) begin
                        state_d = S_ON;
                    end else begin
                        non_d = non_q + c_NW'(1);
                        cnt_d = DLY;
                    end
                end
            end
            S_ON: begin
                if (!PWR_REQ) begin
                    state_d = S_ISO;
                end
            end
            S_ISO: begin
                state_d = S_DN;
                non_d   = non_q - c_NW'(1);
                cnt_d   = DLY;
            end
            S_DN: begin
                if (PWR_REQ) begin
                    state_d = S_UP;
                    non_d   = non_q + c_NW'(1);
                    cnt_d   = DLY;
                end else if (cnt_zero && !dn_ack) begin
                    if (non_q == '0) begin
                        state_d = S_OFF;
                    end else begin
                        non_d = non_q - c_NW'(1);
                        cnt_d = DLY;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                non_d   = '0;
                cnt_d   = '0;
            end
        endcase

`ifdef GF180MCU_FD_SC_MCU9T5V0_PWRSW_TIMEOUT_EN
        fault_d = fault_q;
        wait_d  = stall ? wait_q + c_WW'(1) : '0;
        // A stuck ack forces the domain off and latches the fault.
        if (stall && wait_q == c_WW'(TMO_CYC - 1)) begin
            fault_d = 1'b1;
            state_d = S_OFF;
            non_d   = '0;
            cnt_d   = '0;
            wait_d  = '0;
        end
`endif

        sw_en_d = '0;
        for (int i = 0; i < NSEG; i++) begin
            sw_en_d[i] = (non_d > c_NW'(i));
        end
        iso_d  = (state_d != S_ON);
        pg_d   = (state_d == S_ON);
        busy_d = (state_d == S_UP) || (state_d == S_ISO) || (state_d == S_DN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_OFF;
            non_q   <= '0;
            cnt_q   <= '0;
            sw_en_q <= '0;
            iso_q   <= 1'b1;
            pg_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            non_q   <= non_d;
            cnt_q   <= cnt_d;
            sw_en_q <= sw_en_d;
            iso_q   <= iso_d;
            pg_q    <= pg_d;
            busy_q  <= busy_d;
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0_PWRSW_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end
`endif

    assign SW_EN    = sw_en_q;
    assign ISO_EN   = iso_q;
    assign PWR_GOOD = pg_q;
    assign BUSY     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq
// Brief   : Self-checking bench: vector table, ramp sequences, random run
//           against a direction/segment-count reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq;

    localparam int NSEG = 4;
    localparam int TMO  = 8;

    logic            clk;
    logic            rst;
    logic            req;
    logic [3:0]      dly;
    logic [NSEG-1:0] ack;
    logic [NSEG-1:0] sw_en;
    logic            iso_en;
    logic            pwr_good;
    logic            busy;
    logic            fault;

    int total = 0;
    int bad   = 0;

    bit              follow = 0;
    logic [NSEG-1:0] prev_sw = '0;

    // Reference model: segment count, ramp direction, ON / isolation-slot flags.
    int m_n, m_dir, m_cnt, m_wait;
    bit m_on, m_iso, m_fault;

    typedef struct {
        bit         rst;
        bit         req;
        int         dly;
        logic [3:0] ack;
        logic [3:0] sw;
        bit         iso;
        bit         pg;
        bit         busy;
    } vec_t;

    vec_t vt[28];

    gf180mcu_fd_sc_mcu9t5v0__pwrsw_seq #(
        .NSEG    (NSEG),
        .DLY_W   (4),
        .TMO_CYC (TMO)
    ) u_dut (
        .CLK      (clk),
        .RST      (rst),
        .PWR_REQ  (req),
        .DLY      (dly),
        .SW_ACK   (ack),
        .SW_EN    (sw_en),
        .ISO_EN   (iso_en),
        .PWR_GOOD (pwr_good),
        .BUSY     (busy),
        .FAULT    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic model_edge();
        int seg;
        bit waiting;
        if (rst) begin
            m_n = 0; m_dir = 0; m_cnt = 0; m_wait = 0;
            m_on = 0; m_iso = 0; m_fault = 0;
            return;
        end
        waiting = 0;
        if (m_iso) begin
            m_iso = 0; m_dir = -1; m_n = m_n - 1; m_cnt = int'(dly);
        end else if (m_on) begin
            if (!req) begin m_on = 0; m_iso = 1; end
        end else if (m_dir == 0) begin
            if (req && !m_fault) begin m_dir = 1; m_n = 1; m_cnt = int'(dly); end
        end else if (req != (m_dir > 0)) begin
            m_dir = -m_dir; m_n = m_n + m_dir; m_cnt = int'(dly);
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
        end else begin
            seg = (m_dir > 0) ? m_n - 1 : m_n;
            if (ack[seg] != (m_dir > 0)) waiting = 1;
            else if (m_dir > 0 && m_n == NSEG) begin m_dir = 0; m_on = 1; end
            else if (m_dir < 0 && m_n == 0) m_dir = 0;
            else begin m_n = m_n + m_dir; m_cnt = int'(dly); end
        end
        m_wait = waiting ? m_wait + 1 : 0;
`ifdef GF180MCU_FD_SC_MCU9T5V0_PWRSW_TIMEOUT_EN
        if (m_wait == TMO) begin
            m_fault = 1; m_dir = 0; m_n = 0; m_on = 0; m_iso = 0; m_wait = 0;
        end
`endif
    endtask

    task automatic tick();
        if (follow) ack = prev_sw;
        prev_sw = sw_en;
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string nm);
        logic [NSEG-1:0] esw;
        bit ebusy;
        esw   = NSEG'((1 << m_n) - 1);
        ebusy = (m_dir != 0) || m_iso;
        total++;
        if (sw_en !== esw || iso_en !== !m_on || pwr_good !== m_on ||
            busy !== ebusy || fault !== m_fault) begin
            bad++;
            $display("FAIL %s: got sw=%b iso=%b pg=%b busy=%b fault=%b want sw=%b iso=%b pg=%b busy=%b fault=%b",
                     nm, sw_en, iso_en, pwr_good, busy, fault, esw, !m_on, m_on, ebusy, m_fault);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic do_reset();
        follow = 0; rst = 1; req = 0; dly = '0; ack = '0;
        tick();
        rst = 0;
    endtask

    initial begin
        int t_up[5];
        int t_dn[5];
        int t_pg, t_iso, t_off;
        logic [NSEG-1:0] pat;

        vt[0]  = '{1'b1, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 1'b1, 0, 4'b0001, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 1'b1, 0, 4'b0001, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b1, 0, 4'b1110, 4'b0111, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 1'b1, 0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b1, 0, 4'b1111, 4'b0111, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 0, 4'b1111, 4'b0111, 1'b1, 1'b0, 1'b1};
        vt[12] = '{1'b0, 1'b0, 0, 4'b0111, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[13] = '{1'b0, 1'b1, 0, 4'b0111, 4'b0111, 1'b1, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b0, 0, 4'b0111, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[15] = '{1'b0, 1'b0, 0, 4'b0111, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[16] = '{1'b0, 1'b0, 0, 4'b0000, 4'b0001, 1'b1, 1'b0, 1'b1};
        vt[17] = '{1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1};
        vt[18] = '{1'b0, 1'b0, 0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1};
        vt[19] = '{1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
        vt[20] = '{1'b0, 1'b1, 2, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1};
        vt[21] = '{1'b0, 1'b1, 2, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1};
        vt[22] = '{1'b0, 1'b1, 2, 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1};
        vt[23] = '{1'b0, 1'b1, 2, 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[24] = '{1'b0, 1'b1, 0, 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[25] = '{1'b0, 1'b1, 0, 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b1};
        vt[26] = '{1'b0, 1'b1, 0, 4'b1111, 4'b0111, 1'b1, 1'b0, 1'b1};
        vt[27] = '{1'b1, 1'b1, 0, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0};

        rst = 1; req = 0; dly = '0; ack = '0;
        @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            rst = vt[i].rst; req = vt[i].req; dly = 4'(vt[i].dly); ack = vt[i].ack;
            tick();
            total++;
            if (sw_en !== vt[i].sw || iso_en !== vt[i].iso || pwr_good !== vt[i].pg ||
                busy !== vt[i].busy || fault !== 1'b0) begin
                bad++;
                $display("FAIL vec%0d: got sw=%b iso=%b pg=%b busy=%b fault=%b want sw=%b iso=%b pg=%b busy=%b fault=0",
                         i, sw_en, iso_en, pwr_good, busy, fault,
                         vt[i].sw, vt[i].iso, vt[i].pg, vt[i].busy);
            end
        end

        // Ramp up with DLY=2 and an ack that trails SW_EN by one cycle.
        do_reset();
        check_model("reset");
        for (int n = 0; n < 5; n++) begin t_up[n] = -1; t_dn[n] = -1; end
        t_pg = -1;
        req = 1; dly = 4'd2; follow = 1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check_model("ramp_up");
            for (int n = 1; n <= NSEG; n++) begin
                pat = NSEG'((1 << n) - 1);
                if (sw_en == pat && t_up[n] < 0) t_up[n] = c;
            end
            if (pwr_good && t_pg < 0) t_pg = c;
        end
        chk_int("up_first_seg", t_up[1], 1);
        chk_int("up_step2", t_up[2] - t_up[1], 3);
        chk_int("up_step3", t_up[3] - t_up[2], 3);
        chk_int("up_step4", t_up[4] - t_up[3], 3);
        chk_int("up_pgood", t_pg - t_up[4], 3);

        t_iso = -1; t_off = -1;
        req = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            check_model("ramp_dn");
            if (t_iso < 0 && sw_en == 4'b1111 && iso_en && !pwr_good) t_iso = c;
            for (int n = 0; n < NSEG; n++) begin
                pat = NSEG'((1 << n) - 1);
                if (sw_en == pat && t_dn[n] < 0) t_dn[n] = c;
            end
            if (t_off < 0 && !busy) t_off = c;
        end
        chk_int("dn_iso", t_iso, 1);
        chk_int("dn_seg3", t_dn[3], 2);
        chk_int("dn_seg2", t_dn[2], 5);
        chk_int("dn_seg1", t_dn[1], 8);
        chk_int("dn_seg0", t_dn[0], 11);
        chk_int("dn_off", t_off, 14);
        follow = 0;

        // Ack held low forever.
        do_reset();
        req = 1; dly = '0; ack = '0;
        tick();
`ifdef GF180MCU_FD_SC_MCU9T5V0_PWRSW_TIMEOUT_EN
        for (int c = 1; c <= 7; c++) begin
            tick();
            check_model("tmo_wait");
        end
        chk_int("tmo_not_yet", int'(fault), 0);
        tick();
        chk_int("tmo_fault", int'(fault), 1);
        chk_int("tmo_sw_off", int'(sw_en), 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_model("tmo_blocked");
        end
        chk_int("tmo_req_ignored", int'(sw_en), 0);
        rst = 1;
        tick();
        chk_int("tmo_cleared", int'(fault), 0);
        rst = 0;
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            check_model("hold_wait");
        end
        chk_int("hold_sw", int'(sw_en), 1);
        chk_int("hold_nofault", int'(fault), 0);
`endif

        // Random run against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [NSEG-1:0] noise;
            noise = '0;
            for (int b = 0; b < NSEG; b++) noise[b] = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) req = ~req;
            dly = 4'($urandom_range(0, 3));
            ack = prev_sw ^ noise;
            tick();
            check_model("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
